// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the fetch (ic) and data (dc) ports in front of the
// simulation memory; one request in flight, registered one-cycle response pulse.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 16
`endif
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 8
`endif

module mem_arbiter #(
  parameter int ADDR_W = `MEM_ADDR_SIZE,
  parameter int DATA_W = `MEM_BANDWIDTH * 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  input  logic              dc_req_we,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [DATA_W-1:0] dc_req_wdata,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_valid,
  output logic              mem_read_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_next;
  logic              last_grant;
  logic              port;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              grant_ic, grant_dc;
  logic              handshake;
  logic              done;

  // On a tie the port that was not served last wins.
  always_comb begin
    grant_ic  = ic_req_valid && (!dc_req_valid || last_grant);
    grant_dc  = dc_req_valid && (!ic_req_valid || !last_grant);
    handshake = (state == IDLE) && (grant_ic || grant_dc);
  end

  always_comb begin
    state_next      = state;
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    mem_addr        = '0;
    mem_write_data  = '0;
    mem_write_valid = 1'b0;
    mem_read_valid  = 1'b0;
    done            = 1'b0;
    case (state)
      IDLE: begin
        ic_req_ready = grant_ic && !rst;
        dc_req_ready = grant_dc && !rst;
        if (grant_ic || grant_dc) state_next = ISSUE;
      end
      ISSUE: begin
        mem_addr = addr;
        if (we) begin
          mem_write_data  = wdata;
          mem_write_valid = 1'b1;
          done            = 1'b1;
        end else begin
          mem_read_valid = 1'b1;
          done           = mem_valid;
        end
        if (done) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ic_resp_valid = (state == RESP) && !port;
  assign dc_resp_valid = (state == RESP) && port;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      port         <= 1'b0;
      ic_resp_data <= '0;
      dc_resp_data <= '0;
    end else begin
      state <= state_next;
      if (handshake) begin
        last_grant <= grant_dc;
        port       <= grant_dc;
      end
      // Write acks return zero; the fetch port only ever reads.
      if (state == ISSUE && done) begin
        if (port) dc_resp_data <= we ? '0 : mem_data;
        else      ic_resp_data <= mem_data;
      end
    end
  end

  // Request fields are captured at handshake so the requester may move on.
  always_ff @(posedge clk) begin
    if (handshake) begin
      we    <= grant_dc && dc_req_we;
      addr  <= grant_dc ? dc_req_addr : ic_req_addr;
      wdata <= dc_req_wdata;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer placed directly upstream of the simulation `memory` block. It accepts single-word read requests from the instruction-fetch port and read/write requests from the data port. It grants one request at a time, round-robin, and drives the memory's address, write and read-valid pins. It returns read data, or a write acknowledge, to the requester as a registered one-cycle response pulse.

## Interface
- `ADDR_W`, default `` `MEM_ADDR_SIZE `` (16): word address width.
- `DATA_W`, default `` `MEM_BANDWIDTH*8 `` (64): data word width.

- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ic_req_valid` in 1: fetch read request.
- `ic_req_addr` in ADDR_W: fetch word address.
- `ic_req_ready` out 1: fetch request accepted this cycle when high with valid.
- `ic_resp_valid` out 1: one-cycle fetch response pulse.
- `ic_resp_data` out DATA_W: fetch read data; valid only with `ic_resp_valid`.
- `dc_req_valid` in 1: data request.
- `dc_req_we` in 1: 1 = write, 0 = read.
- `dc_req_addr` in ADDR_W: data word address.
- `dc_req_wdata` in DATA_W: write data.
- `dc_req_ready` out 1: data request accepted when high with valid.
- `dc_resp_valid` out 1: one-cycle data response pulse; also acknowledges writes.
- `dc_resp_data` out DATA_W: read data; 0 for write acks.
- `mem_addr` out ADDR_W: to memory.
- `mem_write_data` out DATA_W: to memory.
- `mem_write_valid` out 1: to memory.
- `mem_read_valid` out 1: to memory.
- `mem_data` in DATA_W: from memory.
- `mem_valid` in 1: from memory; read data valid.

## Operation
- FSM states:
  - IDLE → ISSUE when a handshake occurs.
  - ISSUE → RESP on write, or on read with `mem_valid`=1; stays in ISSUE while a read sees `mem_valid`=0.
  - RESP → IDLE unconditionally.
- Arbitration happens in IDLE only. `last_grant` register records the last port served: 0 = IC, 1 = DC.
  - One port valid: that port is granted.
  - Both ports valid: the port not equal to `last_grant` wins.
  - `last_grant` resets to 1, so IC wins the first tie.
- `ic_req_ready` / `dc_req_ready` are combinational: high only in IDLE, for the granted port, when it is valid. Both ports are never ready in the same cycle.
- On handshake, latch the port id, we, addr and wdata, and update `last_grant`. The requester may change or drop its inputs afterwards.
- A requester that drops valid before ready is served no request and gets no response.
- ISSUE, read:
  - `mem_addr` = latched addr; `mem_read_valid` = 1; `mem_write_valid` = 0.
  - On the edge where `mem_valid` = 1, capture `mem_data` into the response register.
- ISSUE, write:
  - `mem_addr` = latched addr; `mem_write_data` = latched wdata; `mem_write_valid` = 1 for exactly one cycle; `mem_read_valid` = 0.
  - Response data register is loaded with 0.
- RESP: `resp_valid` of the latched port only = 1 for one cycle; that port's `resp_data` = captured word.
- Outside ISSUE, `mem_addr`, `mem_write_data`, `mem_write_valid` and `mem_read_valid` are all 0.
- `*_resp_data` holds its last value when `resp_valid` = 0.
- The fetch port never writes; there is no `ic` write path.

## Timing
- Reset values: state IDLE; `last_grant`=1; both readys 0; both resp_valids 0; both resp_datas 0; all `mem_*` outputs 0.
- Reset asserted mid-transaction aborts it: no response is issued and no further memory write occurs.
- Latency with a zero-latency memory (`mem_valid` = `mem_read_valid`):
  - Handshake at edge N.
  - ISSUE during cycle N+1.
  - `resp_valid` high during cycle N+2.
  - IDLE in cycle N+3; next handshake possible in N+3.
  - Throughput: one request per 3 cycles.
- A memory with latency L stretches ISSUE to L+1 cycles. `mem_read_valid` and `mem_addr` stay stable throughout.
- Write becomes visible in memory at the end edge of its ISSUE cycle. A read issued afterwards, to the same address, returns the new data.

## Test plan
- Reset, then IC read addr 0x0010 with ram[0x0010]=0xDEAD_BEEF → `ic_req_ready` same cycle; `mem_read_valid`=1 and `mem_addr`=0x0010 one cycle later; `ic_resp_valid`=1 with data 0xDEAD_BEEF two cycles after handshake.
- DC write addr 0x0200 data 0x1234_5678_9ABC_DEF0, then DC read 0x0200 → `mem_write_valid` for exactly one cycle; write ack with data 0; read returns 0x1234_5678_9ABC_DEF0.
- IC and DC both valid continuously from reset for 4 grants → grant order IC, DC, IC, DC; never two readys in one cycle; each response pulses on the correct port only.
- Memory model with `mem_valid` delayed 3 cycles → ISSUE lasts 4 cycles; address held stable; response follows the capture edge by one cycle.
- `rst` pulsed during ISSUE of a DC write → all outputs 0 immediately; memory location unchanged after the pulse; no `dc_resp_valid`; next request after reset is served normally with IC winning a tie.
- DC valid dropped one cycle before IDLE, during RESP of an IC transaction → no DC handshake, no DC response.
